fetch_line_buffer: RTL
======================

// Module: fetch_line_buffer
// PURPOSE
//  Instruction-fetch front end between the Sysbus and the x86-64 decoder. Issues 64-byte line reads,
//  receives 8 x 64-bit beats, discards bytes before the entry/redirect RIP, and appends the rest
//  to a circular byte buffer. Presents a 15-byte window to the decoder, which returns a consumed-byte count.
// PARAMETERS
//  BUF_BYTES    128       circular buffer size in bytes; power of two, >= 128
//  WIN_BYTES    15        decode window width in bytes (max x86 instruction length)
//  TAG_W        13        Sysbus reqtag width
//  RD_MEM_TAG   {READ,MEMORY,8'b0}  constant reqtag driven on every request
// PORTS
//  clk           in   1        Sysbus clock
//  reset         in   1        asynchronous, active-high
//  entry         in   64       start RIP, sampled while reset is high
//  redirect      in   1        1-cycle pulse: flush and refetch from redirect_rip
//  redirect_rip  in   64       new RIP, valid with redirect
//  reqcyc        out  1        bus request valid (registered)
//  req           out  64       request address, always 64-byte aligned
//  reqtag        out  TAG_W    = RD_MEM_TAG
//  reqack        in   1        bus accepted the request
//  respcyc       in   1        response beat valid
//  resp          in   64       response beat; byte k = resp[8k+7:8k]
//  respack       out  1        = respcyc (combinational; always accepts)
//  win_bytes     out  8*WIN    window; byte j = win_bytes[8j+7:8j] = buf[rd_ptr+j]
//  win_valid     out  1        occ >= WIN_BYTES
//  consume       in   4        bytes retired this cycle (0..15)
// BEHAVIOUR
//  Reset (async): state=IDLE, fetch_rip=entry&~63, skip=entry[5:0], rd_ptr=wr_ptr=occ=beat=0,
//   reqcyc=0, req=0, win_valid=0. Reset mid-transaction abandons it; no beats retained.
//  States: IDLE, REQ, RESP, DRAIN.
//   IDLE: if occ <= BUF_BYTES-64 -> REQ; next cycle reqcyc=1, req=fetch_rip.
//   REQ: reqcyc and req held stable until reqack=1; then reqcyc=0 next cycle, -> RESP, beat=0.
//   RESP: each respcyc beat: line byte i=8*beat+k written at wr_ptr (in k order) iff i >= skip;
//    beat++. On beat 7: skip=0, fetch_rip+=64, -> IDLE. Gaps between beats allowed.
//   DRAIN: swallows beats (respack still 1) without writing until 8 counted -> IDLE.
//  Occupancy: occ' = occ + bytes_written - consume_eff; range 0..BUF_BYTES, never overflows
//   because a line is only requested when >= 64 bytes are free. Pointers wrap mod BUF_BYTES;
//   window read wraps (rd_ptr=120 -> bytes 120..127,0..6).
//  consume_eff = consume if win_valid else 0 (consume while !win_valid is ignored; assertion fires).
//   consume > 15 impossible by width; consume <= occ guaranteed when win_valid.
//   Simultaneous write and consume in one cycle: both applied.
//  Redirect (highest priority, same cycle): rd_ptr=wr_ptr=occ=0, consume ignored, beats that cycle
//   discarded; fetch_rip=redirect_rip&~63, skip=redirect_rip[5:0]. From IDLE -> IDLE.
//   From REQ: keep reqcyc/req (old address) until reqack, then -> DRAIN. From RESP -> DRAIN,
//   beat counter continues. Redirect during DRAIN just updates fetch_rip/skip.
//  Latency: first byte visible in win_bytes the cycle after the beat carrying it; win_valid
//   asserts the cycle after occ reaches 15.
// TESTING
//  1. entry=0x1000, ack 1 cycle after reqcyc, beats 0x0706050403020100+0x0808080808080808*n
//     -> req=0x1000, after beat 7 occ=64, win_bytes[7:0]=0x00, win_bytes[119:112]=0x0E, win_valid=1.
//  2. entry=0x1005, same beats -> occ=59, win_bytes[7:0]=0x05; next req=0x1040.
//  3. No consume -> two lines fetched, occ=128, no 3rd reqcyc; consume 15 x4 -> occ=68, still none;
//     one more consume=4 -> occ=64, reqcyc=1 with req=0x1080.
//  4. Advance rd_ptr to 120 with 128 bytes written -> window = bytes 120..127,0..6, correct values.
//  5. Redirect to 0x2010 after beat 3 -> occ=0, beats 4..7 dropped, next req=0x2000, line yields
//     occ=48, win_bytes[7:0]=byte 0x10 of line.
//  6. Assert reset between clk edges during RESP -> reqcyc=0, win_valid=0 immediately; after
//     release req=entry&~63 and stale late beats are not written.

Source files
------------

// File: rtl/fetch_line_buffer.sv
// Instruction-fetch line buffer: fetches 64-byte lines over the Sysbus, drops bytes ahead of
// the start RIP, and serves a wrapping 15-byte decode window out of a circular byte buffer.
module fetch_line_buffer #(
  parameter int               BUF_BYTES  = 128,
  parameter int               WIN_BYTES  = 15,
  parameter int               TAG_W      = 13,
  parameter logic [TAG_W-1:0] RD_MEM_TAG = 13'h1100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [63:0]            entry,
  input  logic                   redirect,
  input  logic [63:0]            redirect_rip,
  output logic                   reqcyc,
  output logic [63:0]            req,
  output logic [TAG_W-1:0]       reqtag,
  input  logic                   reqack,
  input  logic                   respcyc,
  input  logic [63:0]            resp,
  output logic                   respack,
  output logic [8*WIN_BYTES-1:0] win_bytes,
  output logic                   win_valid,
  input  logic [3:0]             consume
);

  localparam int PW = $clog2(BUF_BYTES);
  localparam int OW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t        state_r;
  logic [63:0]   fetch_rip_r;
  logic [5:0]    skip_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [OW-1:0] occ_r;
  logic [2:0]    beat_r;
  logic          drain_pend_r;
  logic          reqcyc_r;
  logic [63:0]   req_r;
  logic          win_valid_r;
  logic [7:0]    buf_r [BUF_BYTES];

  logic          beat_live_s;
  logic [5:0]    line_idx_s;
  logic [7:0]    wr_en_s;
  logic [PW-1:0] wr_idx_s [8];
  logic [3:0]    nwr_s;
  logic [3:0]    consume_eff_s;
  logic [OW-1:0] occ_next_s;

  assign reqcyc    = reqcyc_r;
  assign req       = req_r;
  assign reqtag    = RD_MEM_TAG;
  assign respack   = respcyc;
  assign win_valid = win_valid_r;

  // Per-byte write enables and packed destinations for the beat on the bus.
  // Kept bytes of a beat form a contiguous tail, so a running count gives each slot.
  always_comb begin
    beat_live_s = respcyc && (state_r == RESP) && !redirect;
    nwr_s       = 4'd0;
    line_idx_s  = 6'd0;
    wr_en_s     = 8'd0;
    for (int k = 0; k < 8; k++) begin
      line_idx_s  = {beat_r, 3'(k)};
      wr_en_s[k]  = beat_live_s && (line_idx_s >= skip_r);
      wr_idx_s[k] = wr_ptr_r + PW'(nwr_s);
      if (wr_en_s[k]) begin
        nwr_s = nwr_s + 4'd1;
      end else begin
        nwr_s = nwr_s;
      end
    end
  end

  // Occupancy bookkeeping; a redirect empties the buffer regardless of traffic.
  always_comb begin
    consume_eff_s = win_valid_r ? consume : 4'd0;
    if (redirect) begin
      occ_next_s = {OW{1'b0}};
    end else begin
      occ_next_s = occ_r + OW'(nwr_s) - OW'(consume_eff_s);
    end
  end

  // Decode window, wrapping around the end of the circular buffer.
  always_comb begin
    win_bytes = '0;
    for (int j = 0; j < WIN_BYTES; j++) begin
      win_bytes[8*j +: 8] = buf_r[rd_ptr_r + PW'(j)];
    end
  end

  // Byte storage; data needs no reset since occupancy gates what is visible.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      if (wr_en_s[k]) begin
        buf_r[wr_idx_s[k]] <= resp[8*k +: 8];
      end
    end
  end

  // Fetch FSM, pointers and registered bus outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      fetch_rip_r  <= {entry[63:6], 6'd0};
      skip_r       <= entry[5:0];
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      occ_r        <= {OW{1'b0}};
      beat_r       <= 3'd0;
      drain_pend_r <= 1'b0;
      reqcyc_r     <= 1'b0;
      req_r        <= 64'd0;
      win_valid_r  <= 1'b0;
    end else begin
      occ_r       <= occ_next_s;
      win_valid_r <= (occ_next_s >= OW'(WIN_BYTES));
      if (redirect) begin
        rd_ptr_r    <= {PW{1'b0}};
        wr_ptr_r    <= {PW{1'b0}};
        fetch_rip_r <= {redirect_rip[63:6], 6'd0};
        skip_r      <= redirect_rip[5:0];
      end else begin
        rd_ptr_r <= rd_ptr_r + PW'(consume_eff_s);
        wr_ptr_r <= wr_ptr_r + PW'(nwr_s);
      end
      case (state_r)
        IDLE: begin
          // Only request when a whole line is guaranteed to fit.
          if (!redirect && (occ_r <= OW'(BUF_BYTES - 64))) begin
            state_r  <= REQ;
            reqcyc_r <= 1'b1;
            req_r    <= fetch_rip_r;
          end
        end
        REQ: begin
          if (reqack) begin
            reqcyc_r     <= 1'b0;
            beat_r       <= 3'd0;
            drain_pend_r <= 1'b0;
            state_r      <= (redirect || drain_pend_r) ? DRAIN : RESP;
          end else if (redirect) begin
            drain_pend_r <= 1'b1;
          end
        end
        RESP: begin
          if (respcyc) begin
            beat_r <= beat_r + 3'd1;
            if (beat_r == 3'd7) begin
              state_r <= IDLE;
              if (!redirect) begin
                skip_r      <= 6'd0;
                fetch_rip_r <= fetch_rip_r + 64'd64;
              end
            end else if (redirect) begin
              state_r <= DRAIN;
            end
          end else if (redirect) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (respcyc) begin
            beat_r <= beat_r + 3'd1;
            if (beat_r == 3'd7) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
